fetch_queue_unit: RTL and testbench

- Parametrised successor to the single-register instruction fetcher.
- Issues one outstanding request at a time to the icache and predecodes each returned word: JAL redirects, branches follow the predictor, JALR stalls until resolved.
- Fetched instructions go into a DEPTH-entry FIFO drained by the issue unit through a valid/ready handshake.
- Sits between icache/predictor and the issue unit; flush and JALR-resolve come from the CDB.

---
 rtl/fetch_queue_unit_pkg.sv | 13 +
 rtl/fetch_queue_unit_if.sv | 26 ++
 rtl/fetch_queue_unit_fifo.sv | 42 ++++
 rtl/fetch_queue_unit.sv | 127 ++++++++++++
 tb/tb_fetch_queue_unit.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// fetch_pkg: opcodes, FSM state encoding and J/B immediate decoders shared by the fetch queue unit.
package fetch_pkg;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_STALL} state_e;
  function automatic logic signed [20:0] j_imm(input logic [31:0] i);
    return {i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction
  function automatic logic signed [12:0] b_imm(input logic [31:0] i);
    return {i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: icache/predictor, issue-side and CDB signals of the fetch queue unit.
interface fetch_queue_unit_if #(parameter int XLEN = 32);
  logic ic_req_valid;
  logic [XLEN-1:0] ic_req_addr;
  logic ic_resp_valid;
  logic [XLEN-1:0] ic_resp_instr;
  logic [XLEN-1:0] pred_addr;
  logic pred_taken;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic out_pred_taken;
  logic flush;
  logic [XLEN-1:0] flush_pc;
  logic jalr_valid;
  logic [XLEN-1:0] jalr_target;
  modport master (
    output ic_req_valid, ic_req_addr, pred_addr, out_valid, out_instr, out_pc, out_pred_taken,
    input ic_resp_valid, ic_resp_instr, pred_taken, out_ready, flush, flush_pc, jalr_valid, jalr_target
  );
  modport slave (
    input ic_req_valid, ic_req_addr, pred_addr, out_valid, out_instr, out_pc, out_pred_taken,
    output ic_resp_valid, ic_resp_instr, pred_taken, out_ready, flush, flush_pc, jalr_valid, jalr_target
  );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// fetch_fifo: power-of-two register FIFO with clear; the head is read straight from the storage flops.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 65
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = wdata;
    rd_d = clear ? '0 : rd_q + AW'(pop);
    wr_d = clear ? '0 : wr_q + AW'(push);
    count_d = clear ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk)
    if (rst) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else if (en) begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  assign rdata = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: single-outstanding icache fetcher with predecode redirect and a QUEUE_DEPTH output FIFO.
// Optional return-address stack enabled by defining FETCH_RAS_EN.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  fetch_queue_unit_if.master bus
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int EW = 2 * XLEN + 1;
  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || RAS_DEPTH < 1)
    $error("fetch_queue_unit: QUEUE_DEPTH must be a power of two >= 2 and RAS_DEPTH >= 1");
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, seq_pc;
  logic discard_q, discard_d, req, push, pop, flag;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic [31:0] ins;
  assign ins = bus.ic_resp_instr[31:0];
  assign seq_pc = pc_q + XLEN'(4);
`ifdef FETCH_RAS_EN
  localparam int RW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [RW-1:0] sp_q, sp_d, sp_up;
  logic [RW:0] rn_q, rn_d;
  logic link_rd, link_rs1;
  assign link_rd = ins[11:7] == 5'd1 || ins[11:7] == 5'd5;
  assign link_rs1 = ins[19:15] == 5'd1 || ins[19:15] == 5'd5;
  assign sp_up = sp_q == RW'(RAS_DEPTH - 1) ? '0 : sp_q + 1'b1;
`endif
  // A flush in the same cycle as a request would orphan it, so flush also gates req.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    discard_d = discard_q;
    push = 1'b0;
    flag = 1'b0;
`ifdef FETCH_RAS_EN
    ras_d = ras_q;
    sp_d = sp_q;
    rn_d = rn_q;
`endif
    req = !rst && rdy && !bus.flush && !discard_q && state_q == ST_FETCH && count < CW'(QUEUE_DEPTH);
    if (bus.flush) begin
      pc_d = bus.flush_pc;
      state_d = ST_FETCH;
      discard_d = !bus.ic_resp_valid && (state_q == ST_WAIT || discard_q);
`ifdef FETCH_RAS_EN
      sp_d = '0;
      rn_d = '0;
`endif
    end else if (discard_q) begin
      discard_d = !bus.ic_resp_valid;
    end else if (req) begin
      state_d = ST_WAIT;
    end else if (state_q == ST_WAIT && bus.ic_resp_valid) begin
      push = 1'b1;
      flag = ins[6:0] == OP_BRANCH && bus.pred_taken;
      pc_d = ins[6:0] == OP_JAL ? pc_q + XLEN'(j_imm(ins)) : flag ? pc_q + XLEN'(b_imm(ins)) : seq_pc;
      state_d = ins[6:0] == OP_JALR ? ST_STALL : ST_FETCH;
`ifdef FETCH_RAS_EN
      if ((ins[6:0] == OP_JAL || ins[6:0] == OP_JALR) && link_rd) begin
        sp_d = sp_up;
        ras_d[sp_up] = seq_pc;
        rn_d = rn_q + (RW+1)'(rn_q != (RW+1)'(RAS_DEPTH));
      end
      if (ins[6:0] == OP_JALR && link_rs1 && !link_rd && rn_q != '0) begin
        pc_d = ras_q[sp_q];
        state_d = ST_FETCH;
        flag = 1'b1;
        sp_d = sp_q == '0 ? RW'(RAS_DEPTH - 1) : sp_q - 1'b1;
        rn_d = rn_q - 1'b1;
      end
`endif
    end else if (state_q == ST_STALL && bus.jalr_valid) begin
      pc_d = bus.jalr_target;
      state_d = ST_FETCH;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q <= RESET_PC;
      discard_q <= 1'b0;
`ifdef FETCH_RAS_EN
      ras_q <= '{default: '0};
      sp_q <= '0;
      rn_q <= '0;
`endif
    end else if (rdy) begin
      state_q <= state_d;
      pc_q <= pc_d;
      discard_q <= discard_d;
`ifdef FETCH_RAS_EN
      ras_q <= ras_d;
      sp_q <= sp_d;
      rn_q <= rn_d;
`endif
    end
  assign pop = bus.out_valid && bus.out_ready;
  fetch_fifo #(.DEPTH(QUEUE_DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .en(rdy),
    .push(push),
    .pop(pop),
    .clear(bus.flush),
    .wdata({bus.ic_resp_instr, pc_q, flag}),
    .rdata(head),
    .count(count)
  );
  assign bus.ic_req_valid = req;
  assign bus.ic_req_addr = pc_q;
  assign bus.pred_addr = pc_q;
  assign bus.out_valid = count != '0;
  assign bus.out_instr = head[EW-1:XLEN+1];
  assign bus.out_pc = head[XLEN:1];
  assign bus.out_pred_taken = head[0];
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: random icache/consumer/CDB traffic checked against a queue-based fetch model.
module tb_fetch_queue_unit;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  typedef struct {logic [31:0] instr; logic [31:0] pc; logic flag;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  fetch_queue_unit_if #(.XLEN(XLEN)) bus ();
  fetch_queue_unit #(.XLEN(XLEN), .QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0), .RAS_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    ent_t exp_q[$];
    ent_t e;
    logic [31:0] m_pc, fpc, tgt, instr, npc;
    logic [20:0] ji;
    logic [12:0] bi;
    int m_st, lat, sz, cls;
    bit m_disc, pend, fl, rs, jv, orr, pt, ereq;
    m_pc = 32'h0;
    m_st = 0;
    m_disc = 0;
    pend = 0;
    lat = 0;
    cls = 0;
    ji = '0;
    bi = '0;
    instr = '0;
    bus.ic_resp_valid = 0;
    bus.ic_resp_instr = '0;
    bus.pred_taken = 0;
    bus.out_ready = 0;
    bus.flush = 0;
    bus.flush_pc = '0;
    bus.jalr_valid = 0;
    bus.jalr_target = '0;
    rdy = 1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_valid", bus.ic_req_valid, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_flag", bus.out_pred_taken, 0);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      #1;
      rst = 0;
      rdy = $urandom_range(0, 19) != 0;
      fl = rdy && $urandom_range(0, 39) == 0;
      rs = rdy && pend && lat == 1;
      pt = $urandom_range(0, 1) == 1;
      jv = rdy && (m_st == 2 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 19) == 0);
      tgt = $urandom & ~32'h3;
      fpc = $urandom & ~32'h3;
      orr = (cyc / 200) % 3 == 2 ? 1'b0 : $urandom_range(0, 9) < 7;
      if (rs) begin
        cls = $urandom_range(0, 19);
        cls = cls < 10 ? 0 : cls < 13 ? 1 : cls < 18 ? 2 : 3;
        ji = 21'($urandom) & ~21'd1;
        bi = 13'($urandom) & ~13'd1;
        case (cls)
          1: instr = {ji[20], ji[10:1], ji[11], ji[19:12], 5'($urandom), 7'h6f};
          2: instr = {bi[12], bi[10:5], 5'($urandom), 5'($urandom), 3'($urandom), bi[4:1], bi[11], 7'h63};
          3: instr = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h67};
          default: instr = {25'($urandom), $urandom_range(0, 1) == 1 ? 7'h13 : 7'h33};
        endcase
      end
      bus.flush = fl;
      bus.flush_pc = fpc;
      bus.ic_resp_valid = rs;
      bus.ic_resp_instr = rs ? instr : $urandom;
      bus.pred_taken = pt;
      bus.jalr_valid = jv;
      bus.jalr_target = tgt;
      bus.out_ready = orr;
      #1;
      if (!rdy) begin
        check("frozen_req_valid", bus.ic_req_valid, 0);
        continue;
      end
      sz = exp_q.size();
      ereq = m_st == 0 && !m_disc && sz < DEPTH && !fl;
      check("req_valid", bus.ic_req_valid, ereq);
      if (ereq) check("req_addr", bus.ic_req_addr, m_pc);
      check("out_valid", bus.out_valid, sz > 0);
      if (sz > 0) begin
        check("out_instr", bus.out_instr, exp_q[0].instr);
        check("out_pc", bus.out_pc, exp_q[0].pc);
        check("out_flag", bus.out_pred_taken, exp_q[0].flag);
      end
      if (rs && m_st == 1 && !fl && !m_disc) check("pred_addr", bus.pred_addr, m_pc);
      if (sz > 0 && orr && !fl) void'(exp_q.pop_front());
      if (fl) begin
        exp_q.delete();
        m_pc = fpc;
        m_st = 0;
        m_disc = pend && !rs;
      end else if (m_disc) begin
        if (rs) m_disc = 0;
      end else if (ereq) begin
        m_st = 1;
      end else if (rs && m_st == 1) begin
        e.instr = instr;
        e.pc = m_pc;
        e.flag = cls == 2 && pt;
        npc = m_pc + 32'd4;
        if (cls == 1) npc = m_pc + {{11{ji[20]}}, ji};
        if (cls == 2 && pt) npc = m_pc + {{19{bi[12]}}, bi};
        exp_q.push_back(e);
        m_pc = npc;
        m_st = cls == 3 ? 2 : 0;
      end else if (m_st == 2 && jv) begin
        m_pc = tgt;
        m_st = 0;
      end
      if (rs) pend = 0;
      else if (pend) lat--;
      if (ereq) begin
        pend = 1;
        lat = $urandom_range(1, 3);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
